// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

    localparam int DW_N_DEF = 32;
    localparam int DW_D_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bits needed to count 0..value-1 (value >= 2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_divider_32_16_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step
    import seq_div_pkg::*;
#(
    parameter int DW_D = DW_D_DEF
) (
    input  logic [DW_D:0]   rem_in,
    input  logic [DW_D-1:0] divisor,
    input  logic            bit_in,
    output logic [DW_D:0]   rem_out,
    output logic            q_bit
);

    logic [DW_D+1:0] shifted;
    logic [DW_D:0]   diff;

    // The full shifted width takes part in the compare so a carry out of the
    // partial remainder can never be mistaken for a smaller value.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted[DW_D:0] - {1'b0, divisor};
        q_bit   = (shifted >= {2'b00, divisor});
        rem_out = q_bit ? diff : shifted[DW_D:0];
    end

endmodule

// File: rtl/seq_divider_32_16.sv
// Iterative 32/16 restoring divider with valid/ready handshakes, one quotient bit per cycle.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider_32_16
    import seq_div_pkg::*;
#(
    parameter int DW_N = DW_N_DEF,
    parameter int DW_D = DW_D_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = (clog2(DW_N) < 1) ? 1 : clog2(DW_N);

    state_t          state, state_next;
    logic            accept, last_step;
    logic [CW-1:0]   count;
    logic [DW_N-1:0] dq;
    logic [DW_D:0]   rem;
    logic [DW_D-1:0] dvsr;
    logic [DW_D-1:0] dz_rem;
    logic            dz_flag;

    logic [DW_D:0]   rem_next;
    logic            q_bit;
    logic [DW_N-1:0] dividend_mag, quot_mag, quot_final;
    logic [DW_D-1:0] divisor_mag, rem_mag, rem_final;

    div_step #(.DW_D(DW_D)) u_step (
        .rem_in  (rem),
        .divisor (dvsr),
        .bit_in  (dq[DW_N-1]),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // dq shifts dividend bits out at the top while quotient bits enter at the bottom.
    assign quot_mag = {dq[DW_N-2:0], q_bit};
    assign rem_mag  = rem_next[DW_D-1:0];

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q, neg_r;

    assign dividend_mag = dividend[DW_N-1] ? -dividend : dividend;
    assign divisor_mag  = divisor[DW_D-1]  ? -divisor  : divisor;
    assign quot_final   = neg_q ? -quot_mag : quot_mag;
    assign rem_final    = neg_r ? -rem_mag  : rem_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[DW_N-1] ^ divisor[DW_D-1];
            neg_r <= dividend[DW_N-1];
        end
    end
`else
    assign dividend_mag = dividend;
    assign divisor_mag  = divisor;
    assign quot_final   = quot_mag;
    assign rem_final    = rem_mag;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last_step  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            dq          <= '0;
            rem         <= '0;
            dvsr        <= '0;
            dz_rem      <= '0;
            dz_flag     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            count   <= CW'(DW_N - 1);
            dq      <= dividend_mag;
            rem     <= '0;
            dvsr    <= divisor_mag;
            dz_rem  <= dividend[DW_D-1:0];
            dz_flag <= (divisor == '0);
        end else if (state == CALC) begin
            dq  <= quot_mag;
            rem <= rem_next;
            if (last_step) begin
                // A zero divisor still runs the full schedule; only the result is overridden.
                quotient    <= dz_flag ? '1 : quot_final;
                remainder   <= dz_flag ? dz_rem : rem_final;
                div_by_zero <= dz_flag;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_32_16.sv
// Self-checking bench for seq_divider_32_16: vector table, corner sequences, random ops vs model.
module tb_seq_divider_32_16;

    localparam int LAT = 32;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic        in_ready, out_valid, div_by_zero;
    logic [31:0] dividend, quotient;
    logic [15:0] divisor, remainder;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    seq_divider_32_16 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the mode's rounding/sign rules.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic dz);
        longint sa, sb, sq, sr;
        dz = (b == 16'd0);
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a[15:0];
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            sa = longint'($signed(a));
            sb = longint'($signed(b));
`else
            sa = longint'({32'd0, a});
            sb = longint'({48'd0, b});
`endif
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[31:0];
            r  = sr[15:0];
        end
    endfunction

    task automatic start_op(input string tag, input logic [31:0] a, input logic [15:0] b);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".out_valid_drop"}, out_valid, 0);
        check({tag, ".in_ready_back"}, in_ready, 1);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [15:0] b,
                           input logic [31:0] eq, input logic [15:0] er, input logic edz,
                           input bit early_ready);
        int lat;
        out_ready = early_ready;
        start_op(tag, a, b);
        wait_done(lat);
        check({tag, ".latency"}, lat, LAT);
        check({tag, ".quotient"}, quotient, eq);
        check({tag, ".remainder"}, remainder, er);
        check({tag, ".div_by_zero"}, div_by_zero, edz);
        release_op(tag);
    endtask

    initial begin
        logic [31:0] ra, mq;
        logic [15:0] rb, mr;
        logic        mdz;
        int          lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("reset.in_ready", in_ready, 1);
        check("reset.out_valid", out_valid, 0);
        check("reset.quotient", quotient, 0);
        check("reset.remainder", remainder, 0);
        check("reset.div_by_zero", div_by_zero, 0);

`ifdef SEQ_DIV_SIGNED_EN
        vecs[0] = '{32'h0001_E240, 16'h0100, 32'h0000_01E2, 16'h0040, 1'b0};
        vecs[1] = '{32'h0000_0005, 16'h0000, 32'hFFFF_FFFF, 16'h0005, 1'b1};
        vecs[2] = '{32'hFFFF_FF9C, 16'h0007, 32'hFFFF_FFF2, 16'hFFFE, 1'b0};
        vecs[3] = '{32'h8000_0000, 16'hFFFF, 32'h8000_0000, 16'h0000, 1'b0};
        vecs[4] = '{32'h0000_0064, 16'hFFF9, 32'hFFFF_FFF2, 16'h0002, 1'b0};
        vecs[5] = '{32'hFFFF_FF9C, 16'hFFF9, 32'h0000_000E, 16'hFFFE, 1'b0};
        vecs[6] = '{32'h8000_0000, 16'h8000, 32'h0001_0000, 16'h0000, 1'b0};
        vecs[7] = '{32'hFFFF_FFF9, 16'h0009, 32'h0000_0000, 16'hFFF9, 1'b0};
        vecs[8] = '{32'hFFFF_FF9C, 16'h0000, 32'hFFFF_FFFF, 16'hFF9C, 1'b1};
        vecs[9] = '{32'h0000_0064, 16'h000A, 32'h0000_000A, 16'h0000, 1'b0};
`else
        vecs[0] = '{32'h0001_E240, 16'h0100, 32'h0000_01E2, 16'h0040, 1'b0};
        vecs[1] = '{32'h0000_0005, 16'h0000, 32'hFFFF_FFFF, 16'h0005, 1'b1};
        vecs[2] = '{32'h0000_0064, 16'h000A, 32'h0000_000A, 16'h0000, 1'b0};
        vecs[3] = '{32'h0000_0007, 16'h0009, 32'h0000_0000, 16'h0007, 1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, 16'h0000, 1'b0};
        vecs[6] = '{32'h8000_0000, 16'hFFFF, 32'h0000_8000, 16'h8000, 1'b0};
        vecs[7] = '{32'hFFFF_FF9C, 16'h0000, 32'hFFFF_FFFF, 16'hFF9C, 1'b1};
        vecs[8] = '{32'h0000_0000, 16'h0005, 32'h0000_0000, 16'h0000, 1'b0};
        vecs[9] = '{32'h0001_0000, 16'h8000, 32'h0000_0002, 16'h0000, 1'b0};
`endif

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].dz, bit'(i % 2));
        end

        // Backpressure: result must hold while in_valid is pulsed and ignored.
        out_ready = 1'b0;
        start_op("bp", 32'h0001_E240, 16'h0100);
        wait_done(lat);
        check("bp.latency", lat, LAT);
        for (int k = 0; k < 10; k++) begin
            in_valid = bit'(k % 2);
            dividend = $urandom;
            divisor  = 16'h0001;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d.out_valid", k), out_valid, 1);
            check($sformatf("bp%0d.in_ready", k), in_ready, 0);
            check($sformatf("bp%0d.quotient", k), quotient, 32'h0000_01E2);
            check($sformatf("bp%0d.remainder", k), remainder, 16'h0040);
        end
        in_valid = 1'b0;
        release_op("bp");

        // Reset landing on the 15th CALC step discards the operation.
        out_ready = 1'b0;
        start_op("rst_mid", 32'h1234_5678, 16'h0003);
        repeat (14) @(posedge clk);
        @(negedge clk);
        check("rst_mid.out_valid_before", out_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.in_ready", in_ready, 1);
        check("rst_mid.out_valid", out_valid, 0);
        check("rst_mid.quotient", quotient, 0);
        check("rst_mid.remainder", remainder, 0);
        check("rst_mid.div_by_zero", div_by_zero, 0);
        run_vec("after_rst", 32'd100, 16'd10, 32'd10, 16'd0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 16'h0000;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            model(ra, rb, mq, mr, mdz);
            run_vec($sformatf("rnd%0d", n), ra, rb, mq, mr, mdz, bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
